// File: rtl/dla_txn_ctrl.sv
// DLA transaction controller.
// Takes one detected DLA transaction at a time, issues a single command to the
// memory scheduler, counts the data beats, and then reports completion.
// A watchdog aborts the transaction if it makes no progress, and raises a
// sticky error flag when it does.
module dla_txn_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int LEN_W   = 8,
   parameter int TMO_CYC = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              tx_detc_i,
   input  logic              txn_rw_i,
   input  logic [ADDR_W-1:0] txn_addr_i,
   input  logic [LEN_W-1:0]  txn_len_i,
   output logic              mem_cmd_valid_o,
   input  logic              mem_cmd_ready_i,
   output logic              mem_cmd_rw_o,
   output logic [ADDR_W-1:0] mem_cmd_addr_o,
   output logic [LEN_W-1:0]  mem_cmd_len_o,
   input  logic              wr_beat_i,
   input  logic              rd_beat_i,
   input  logic              mem_resp_valid_i,
   output logic [2:0]        cur_state_o,
   output logic              tx_resp_cmd_o,
   output logic              busy_o,
   output logic              err_o,
   input  logic              err_clr_i
);

   localparam int WD_W = $clog2(TMO_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WRITE      = 3'd1,
      S_READ       = 3'd2,
      S_WRITE_RESP = 3'd3,
      S_READ_RESP  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_rw;
   logic [ADDR_W-1:0]   r_addr;
   logic [LEN_W-1:0]    r_len;
   logic                r_cmd_valid;
   logic                r_hs_done;
   logic [LEN_W:0]      r_beat_cnt;
   logic [WD_W-1:0]     r_wdog;
   logic                r_err;

   logic                w_start;
   logic                w_handshake;
   logic                w_beat;
   logic                w_last_beat;
   logic                w_resp;
   logic                w_progress;
   logic                w_timeout;
   logic                w_tx_resp;

   // Next-state decode, progress/timeout detection and the completion pulse.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_tx_resp   = 1'b0;

      // Beats only count once the command has been accepted in an earlier cycle.
      w_handshake = r_cmd_valid & mem_cmd_ready_i;
      w_beat      = r_hs_done & (((r_state == S_WRITE) & wr_beat_i) |
                                 ((r_state == S_READ)  & rd_beat_i));
      w_last_beat = w_beat & (r_beat_cnt == {1'b0, r_len});
      w_resp      = (r_state == S_WRITE_RESP) & mem_resp_valid_i;
      w_progress  = w_handshake | w_beat | w_resp;
      // Progress in the expiry cycle resets the watchdog instead of tripping it.
      w_timeout   = (r_state != S_IDLE) & ~w_progress &
                    (r_wdog == WD_W'(TMO_CYC - 1));

      case (r_state)
         S_IDLE: begin
            if (enable && tx_detc_i) begin
               w_start     = 1'b1;
               w_state_nxt = txn_rw_i ? S_WRITE : S_READ;
            end
         end
         S_WRITE: begin
            if (w_last_beat) w_state_nxt = S_WRITE_RESP;
         end
         S_READ: begin
            if (w_last_beat) w_state_nxt = S_READ_RESP;
         end
         S_WRITE_RESP: begin
            if (w_resp) begin
               w_tx_resp   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_READ_RESP: begin
            w_tx_resp   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_timeout) w_state_nxt = S_IDLE;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Command fields and the valid/handshake bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rw        <= 1'b0;
         r_addr      <= '0;
         r_len       <= '0;
         r_cmd_valid <= 1'b0;
         r_hs_done   <= 1'b0;
      end else if (w_start) begin
         r_rw        <= txn_rw_i;
         r_addr      <= txn_addr_i;
         r_len       <= txn_len_i;
         r_cmd_valid <= 1'b1;
         r_hs_done   <= 1'b0;
      end else begin
         if (w_handshake || w_timeout) r_cmd_valid <= 1'b0;
         if (w_handshake)              r_hs_done   <= 1'b1;
      end
   end

   // Beat counter; one extra bit so an all-ones length never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_beat_cnt <= '0;
      else if (w_start) r_beat_cnt <= '0;
      else if (w_beat)  r_beat_cnt <= r_beat_cnt + (LEN_W+1)'(1);
   end

   // Watchdog: counts stalled busy cycles, restarts on any state change or progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_wdog <= '0;
      else if ((r_state == S_IDLE) || (w_state_nxt != r_state) || w_progress)
         r_wdog <= '0;
      else
         r_wdog <= r_wdog + WD_W'(1);
   end

   // Sticky error flag; a new timeout beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;
   end

   assign mem_cmd_valid_o = r_cmd_valid;
   assign mem_cmd_rw_o    = r_rw;
   assign mem_cmd_addr_o  = r_addr;
   assign mem_cmd_len_o   = r_len;
   assign cur_state_o     = r_state;
   assign tx_resp_cmd_o   = w_tx_resp;
   assign busy_o          = (r_state != S_IDLE);
   assign err_o           = r_err;

endmodule

// File: tb/tb_dla_txn_ctrl.sv
// Self-checking bench for dla_txn_ctrl.
// A transaction-level model (beats remaining, stall age) predicts every output
// each cycle; directed scenarios add literal expectations on key events.
module tb_dla_txn_ctrl;

   localparam int AW  = 32;
   localparam int LW  = 4;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          tx_detc_i;
   logic          txn_rw_i;
   logic [AW-1:0] txn_addr_i;
   logic [LW-1:0] txn_len_i;
   logic          mem_cmd_valid_o;
   logic          mem_cmd_ready_i;
   logic          mem_cmd_rw_o;
   logic [AW-1:0] mem_cmd_addr_o;
   logic [LW-1:0] mem_cmd_len_o;
   logic          wr_beat_i;
   logic          rd_beat_i;
   logic          mem_resp_valid_i;
   logic [2:0]    cur_state_o;
   logic          tx_resp_cmd_o;
   logic          busy_o;
   logic          err_o;
   logic          err_clr_i;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_pulse = 0;
   int n_vld   = 0;
   bit started = 1'b0;

   dla_txn_ctrl #(.ADDR_W(AW), .LEN_W(LW), .TMO_CYC(TMO)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .enable           (enable),
      .tx_detc_i        (tx_detc_i),
      .txn_rw_i         (txn_rw_i),
      .txn_addr_i       (txn_addr_i),
      .txn_len_i        (txn_len_i),
      .mem_cmd_valid_o  (mem_cmd_valid_o),
      .mem_cmd_ready_i  (mem_cmd_ready_i),
      .mem_cmd_rw_o     (mem_cmd_rw_o),
      .mem_cmd_addr_o   (mem_cmd_addr_o),
      .mem_cmd_len_o    (mem_cmd_len_o),
      .wr_beat_i        (wr_beat_i),
      .rd_beat_i        (rd_beat_i),
      .mem_resp_valid_i (mem_resp_valid_i),
      .cur_state_o      (cur_state_o),
      .tx_resp_cmd_o    (tx_resp_cmd_o),
      .busy_o           (busy_o),
      .err_o            (err_o),
      .err_clr_i        (err_clr_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // phase: 0 idle, 1 write data, 2 read data, 3 write response, 4 read response
   int            m_phase, n_phase;
   bit            m_pend, n_pend;     // command offered, not yet accepted
   bit            m_acc, n_acc;       // command accepted in an earlier cycle
   int            m_left, n_left;     // beats still owed
   int            m_age, n_age;       // stalled cycles in the current phase
   bit            m_err, n_err;
   bit            m_rw, n_rw;
   logic [AW-1:0] m_addr, n_addr;
   logic [LW-1:0] m_len, n_len;
   bit            moved, expired;

   always_comb begin
      n_phase = m_phase; n_pend = m_pend; n_acc = m_acc; n_left = m_left;
      n_age = m_age; n_err = m_err; n_rw = m_rw; n_addr = m_addr; n_len = m_len;
      moved = 1'b0; expired = 1'b0;
      case (m_phase)
         0: if (enable && tx_detc_i) begin
               n_rw = txn_rw_i; n_addr = txn_addr_i; n_len = txn_len_i;
               n_left = int'(txn_len_i) + 1;
               n_pend = 1'b1; n_acc = 1'b0;
               n_phase = txn_rw_i ? 1 : 2;
            end
         1, 2: begin
               if (m_pend && mem_cmd_ready_i) begin
                  n_pend = 1'b0; n_acc = 1'b1; moved = 1'b1;
               end
               if (m_acc && ((m_phase == 1) ? wr_beat_i : rd_beat_i)) begin
                  n_left = m_left - 1; moved = 1'b1;
                  if (n_left == 0) n_phase = m_phase + 2;
               end
            end
         3: if (mem_resp_valid_i) begin moved = 1'b1; n_phase = 0; end
         4: n_phase = 0;
         default: n_phase = 0;
      endcase
      if (m_phase == 0 || moved || n_phase != m_phase) n_age = 0;
      else begin
         n_age = m_age + 1;
         if (n_age >= TMO) begin
            expired = 1'b1; n_phase = 0; n_pend = 1'b0; n_age = 0;
         end
      end
      if (expired)        n_err = 1'b1;
      else if (err_clr_i) n_err = 1'b0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0; m_pend <= 1'b0; m_acc <= 1'b0; m_left <= 0; m_age <= 0;
         m_err <= 1'b0; m_rw <= 1'b0; m_addr <= '0; m_len <= '0;
      end else begin
         m_phase <= n_phase; m_pend <= n_pend; m_acc <= n_acc; m_left <= n_left;
         m_age <= n_age; m_err <= n_err; m_rw <= n_rw; m_addr <= n_addr; m_len <= n_len;
      end
   end

   // Compare process: inputs change just after posedge, so negedge sees a stable cycle.
   always @(negedge clk) begin
      if (started && rst_n) begin
         check("state", 64'(cur_state_o), 64'(m_phase));
         check("cmd_valid", 64'(mem_cmd_valid_o), 64'(m_pend));
         check("cmd_rw", 64'(mem_cmd_rw_o), 64'(m_rw));
         check("cmd_addr", 64'(mem_cmd_addr_o), 64'(m_addr));
         check("cmd_len", 64'(mem_cmd_len_o), 64'(m_len));
         check("busy", 64'(busy_o), 64'(m_phase != 0));
         check("err", 64'(err_o), 64'(m_err));
         check("tx_resp", 64'(tx_resp_cmd_o),
               64'((m_phase == 4) || (m_phase == 3 && mem_resp_valid_i)));
         if (tx_resp_cmd_o === 1'b1)   n_pulse++;
         if (mem_cmd_valid_o === 1'b1) n_vld++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input bit rw, input logic [AW-1:0] addr, input logic [LW-1:0] len);
      tx_detc_i = 1'b1; txn_rw_i = rw; txn_addr_i = addr; txn_len_i = len;
      tick();
      tx_detc_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int p0, v0, n;
      rst_n = 1'b0; enable = 1'b1; tx_detc_i = 1'b0; txn_rw_i = 1'b0;
      txn_addr_i = '0; txn_len_i = '0; mem_cmd_ready_i = 1'b0; wr_beat_i = 1'b0;
      rd_beat_i = 1'b0; mem_resp_valid_i = 1'b0; err_clr_i = 1'b0;
      tick(); tick();
      check("rst_state", 64'(cur_state_o), 0);
      check("rst_valid", 64'(mem_cmd_valid_o), 0);
      check("rst_busy", 64'(busy_o), 0);
      check("rst_err", 64'(err_o), 0);
      rst_n = 1'b1; started = 1'b1;
      tick();

      // Write len=3, ready with valid, four beats, then response.
      p0 = n_pulse;
      start(1'b1, 32'h1000_0040, 4'd3);
      check("w_enter_write", 64'(cur_state_o), 1);
      check("w_valid_up", 64'(mem_cmd_valid_o), 1);
      mem_cmd_ready_i = 1'b1; tick(); mem_cmd_ready_i = 1'b0;
      check("w_valid_drop", 64'(mem_cmd_valid_o), 0);
      wr_beat_i = 1'b1; repeat (3) tick();
      check("w_after_3_beats", 64'(cur_state_o), 1);
      tick(); wr_beat_i = 1'b0;
      check("w_enter_resp", 64'(cur_state_o), 3);
      wr_beat_i = 1'b1; rd_beat_i = 1'b1; tick(); wr_beat_i = 1'b0; rd_beat_i = 1'b0;
      check("w_resp_holds", 64'(cur_state_o), 3);
      mem_resp_valid_i = 1'b1; tick(); mem_resp_valid_i = 1'b0;
      check("w_back_idle", 64'(cur_state_o), 0);
      check("w_one_pulse", 64'(n_pulse - p0), 1);
      mem_resp_valid_i = 1'b1; tick(); mem_resp_valid_i = 1'b0;

      // Read len=0, ready after five cycles, one beat.
      p0 = n_pulse; v0 = n_vld;
      start(1'b0, 32'hDEAD_BEE0, 4'd0);
      repeat (5) tick();
      mem_cmd_ready_i = 1'b1; tick(); mem_cmd_ready_i = 1'b0;
      check("r_valid_6_cycles", 64'(n_vld - v0), 6);
      rd_beat_i = 1'b1; tick(); rd_beat_i = 1'b0;
      check("r_enter_resp", 64'(cur_state_o), 4);
      check("r_pulse_in_resp", 64'(tx_resp_cmd_o), 1);
      tick();
      check("r_back_idle", 64'(cur_state_o), 0);
      check("r_one_pulse", 64'(n_pulse - p0), 1);

      // Write len=1 with a beat before the handshake.
      start(1'b1, 32'h0000_2000, 4'd1);
      wr_beat_i = 1'b1; tick(); wr_beat_i = 1'b0;
      mem_cmd_ready_i = 1'b1; tick(); mem_cmd_ready_i = 1'b0;
      wr_beat_i = 1'b1; tick();
      check("pre_beat_ignored", 64'(cur_state_o), 1);
      tick(); wr_beat_i = 1'b0;
      check("w2_enter_resp", 64'(cur_state_o), 3);
      mem_resp_valid_i = 1'b1; tick(); mem_resp_valid_i = 1'b0;

      // Progress in the expiry cycle prevents a timeout.
      start(1'b0, 32'h0000_3000, 4'd0);
      repeat (15) tick();
      mem_cmd_ready_i = 1'b1; tick(); mem_cmd_ready_i = 1'b0;
      check("hs_wins_state", 64'(cur_state_o), 2);
      check("hs_wins_err", 64'(err_o), 0);
      repeat (15) tick();
      rd_beat_i = 1'b1; tick(); rd_beat_i = 1'b0;
      check("beat_wins_state", 64'(cur_state_o), 4);
      tick();

      // Read with ready never asserted: watchdog abort.
      p0 = n_pulse;
      start(1'b0, 32'h0000_4000, 4'd2);
      n = 0;
      while (cur_state_o == 3'd2 && n < 40) begin n++; tick(); end
      check("tmo_cycles", 64'(n), 16);
      check("tmo_idle", 64'(cur_state_o), 0);
      check("tmo_err", 64'(err_o), 1);
      check("tmo_valid", 64'(mem_cmd_valid_o), 0);
      check("tmo_no_pulse", 64'(n_pulse - p0), 0);
      err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
      check("err_cleared", 64'(err_o), 0);

      // Timeout with clear held: set wins.
      err_clr_i = 1'b1;
      start(1'b1, 32'h0000_5000, 4'd0);
      n = 0;
      while (cur_state_o == 3'd1 && n < 40) begin n++; tick(); end
      err_clr_i = 1'b0;
      check("set_wins_cycles", 64'(n), 16);
      check("set_wins_err", 64'(err_o), 1);

      // Max length write with err still set, extra detect while busy, enable dropped mid-way.
      start(1'b1, 32'h0000_6000, 4'hF);
      check("max_enter_write", 64'(cur_state_o), 1);
      tx_detc_i = 1'b1; txn_rw_i = 1'b0; txn_addr_i = 32'hFFFF_FFFF; txn_len_i = 4'd2;
      tick(); tx_detc_i = 1'b0;
      check("busy_detect_addr", 64'(mem_cmd_addr_o), 64'h6000);
      mem_cmd_ready_i = 1'b1; tick(); mem_cmd_ready_i = 1'b0;
      enable = 1'b0;
      wr_beat_i = 1'b1; repeat (15) tick();
      check("max_after_15", 64'(cur_state_o), 1);
      tick(); wr_beat_i = 1'b0;
      check("max_after_16", 64'(cur_state_o), 3);
      mem_resp_valid_i = 1'b1; tick(); mem_resp_valid_i = 1'b0;
      check("max_done", 64'(cur_state_o), 0);
      tx_detc_i = 1'b1; txn_rw_i = 1'b1; tick(); tx_detc_i = 1'b0;
      check("disabled_state", 64'(cur_state_o), 0);
      check("disabled_valid", 64'(mem_cmd_valid_o), 0);
      enable = 1'b1;

      // Reset mid-read with valid pending.
      start(1'b0, 32'h0000_7000, 4'd1);
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_state", 64'(cur_state_o), 0);
      check("arst_valid", 64'(mem_cmd_valid_o), 0);
      check("arst_addr", 64'(mem_cmd_addr_o), 0);
      check("arst_len", 64'(mem_cmd_len_o), 0);
      check("arst_busy", 64'(busy_o), 0);
      check("arst_err", 64'(err_o), 0);
      check("arst_resp", 64'(tx_resp_cmd_o), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      tick();
      p0 = n_pulse;
      start(1'b1, 32'h0000_8000, 4'd0);
      mem_cmd_ready_i = 1'b1; tick(); mem_cmd_ready_i = 1'b0;
      wr_beat_i = 1'b1; tick(); wr_beat_i = 1'b0;
      check("post_rst_resp", 64'(cur_state_o), 3);
      mem_resp_valid_i = 1'b1; tick(); mem_resp_valid_i = 1'b0;
      check("post_rst_idle", 64'(cur_state_o), 0);
      check("post_rst_pulse", 64'(n_pulse - p0), 1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dla_txn_ctrl.md
DLA_TXN_CTRL -- requirements
Module: dla_txn_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, command address width.
REQ-002 SHALL have parameter LEN_W, default 8, burst length field width (beats minus one).
REQ-003 SHALL have parameter TMO_CYC, default 1024, watchdog limit in cycles, minimum 4.
REQ-004 SHALL have ports as follows; reset rst_n, asynchronous, active-low; clock clk.
 clk  in  1  clock
 rst_n  in  1  async active-low reset
 enable  in  1  block enable
 tx_detc_i  in  1  new DLA transaction detected (pulse)
 txn_rw_i  in  1  1=write, 0=read; valid with tx_detc_i
 txn_addr_i  in  ADDR_W  transaction address; valid with tx_detc_i
 txn_len_i  in  LEN_W  beats minus one; valid with tx_detc_i
 mem_cmd_valid_o  out  1  command to memory scheduler valid
 mem_cmd_ready_i  in  1  scheduler accepts command
 mem_cmd_rw_o  out  1  latched rw
 mem_cmd_addr_o  out  ADDR_W  latched address
 mem_cmd_len_o  out  LEN_W  latched length
 wr_beat_i  in  1  one write beat popped from write FIFO by memory side
 rd_beat_i  in  1  one read beat pushed into read FIFO
 mem_resp_valid_i  in  1  write completion from memory side
 cur_state_o  out  3  state: IDLE=0, WRITE=1, READ=2, WRITE_RESP=3, READ_RESP=4
 tx_resp_cmd_o  out  1  one-cycle transaction-complete pulse
 busy_o  out  1  cur_state_o != IDLE
 err_o  out  1  sticky watchdog error
 err_clr_i  in  1  clears err_o

Function
REQ-005 In IDLE with enable=1 and tx_detc_i=1: latch rw/addr/len; next cycle state=WRITE (rw=1) or READ (rw=0), mem_cmd_valid_o=1.
REQ-006 tx_detc_i SHALL be ignored outside IDLE and while enable=0 in IDLE.
REQ-007 mem_cmd_valid_o held with rw/addr/len stable until cycle where mem_cmd_ready_i=1; deasserts the following cycle.
REQ-008 Beat counter (LEN_W+1 bits) cleared on entry to WRITE/READ; increments on wr_beat_i in WRITE, rd_beat_i in READ, only in cycles after the command handshake completed; earlier beats ignored.
REQ-009 Beat with counter==latched len: WRITE->WRITE_RESP, READ->READ_RESP next cycle; len all-ones means 2^LEN_W beats, no wrap.
REQ-010 Beats of the opposite type and beats in IDLE/RESP states SHALL be ignored.
REQ-011 WRITE_RESP: on mem_resp_valid_i=1, tx_resp_cmd_o=1 for one cycle, state=IDLE next cycle.
REQ-012 READ_RESP: tx_resp_cmd_o=1 for exactly the single cycle spent in READ_RESP; state=IDLE next cycle.
REQ-013 mem_resp_valid_i outside WRITE_RESP SHALL be ignored.
REQ-014 Watchdog counts cycles in non-IDLE states; cleared on state entry, command handshake, counted beat, or mem_resp_valid_i in WRITE_RESP.
REQ-015 Watchdog reaching TMO_CYC: err_o=1, state=IDLE, mem_cmd_valid_o=0 (abort may drop valid without handshake), no tx_resp_cmd_o.
REQ-016 A progress event in the expiry cycle SHALL win; no timeout.
REQ-017 err_o cleared by err_clr_i; set wins if both occur in the same cycle; err_o does not block new transactions.
REQ-018 enable=0 mid-transaction SHALL NOT abort; transaction completes normally.

Reset
REQ-019 On rst_n=0, immediately: state IDLE, cur_state_o=0, mem_cmd_valid_o=0, rw/addr/len outputs 0, tx_resp_cmd_o=0, busy_o=0, err_o=0, counters 0; reset mid-transaction discards it without response.

Verification
REQ-020 Write len=3, ready same cycle as valid, 4 wr_beat_i, mem_resp_valid_i -> states 0,1,3,0; one tx_resp_cmd_o pulse.
REQ-021 Read len=0, ready after 5 cycles, 1 rd_beat_i -> valid held 6 cycles, fields stable, READ_RESP one cycle with pulse.
REQ-022 Write len=1, wr_beat_i before handshake plus 2 after -> pre-handshake beat ignored, WRITE_RESP after the 2nd counted beat.
REQ-023 TMO_CYC=16, read with ready never asserted -> after 16 cycles err_o=1, valid=0, IDLE, no pulse; err_clr_i clears it.
REQ-024 tx_detc_i while busy, and while enable=0 in IDLE -> no state change, no command.
REQ-025 rst_n low in READ with valid pending -> all outputs 0 asynchronously; subsequent transaction runs normally.
